// File: rtl/pkt_defs_pkg.sv
// Shared definitions for the received-packet deframer.
// Holds the FSM state encoding, the default framing byte and the checksum step.
package pkt_defs_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_HOLD
    } pkt_state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hAA;

    // Running checksum step: 8-bit modular add, carries discarded.
    function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/pkt_buffer.sv
// Payload store for the deframer: DEPTH x 8 RAM, synchronous write, registered read.
// Only the read register is reset; RAM contents are don't-care until written.
module pkt_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/packet_rx_parser.sv
// Byte-stream deframer: SYNC, CMD, LEN, PAYLOAD[LEN], CHK.
// Good packets are held for the consumer until pkt_ack; bad or stalled traffic raises 1-clk error pulses.
module packet_rx_parser
    import pkt_defs_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 5000,
    localparam int        LEN_W        = $clog2(MAX_LEN + 1),
    localparam int        ADDR_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              pkt_valid,
    output logic [7:0]        pkt_cmd,
    output logic [LEN_W-1:0]  pkt_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              pkt_ack,
    output logic              err_chk,
    output logic              err_len,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CLKS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);

    pkt_state_t       state, state_nxt;
    logic [7:0]       sum, sum_nxt;
    logic [LEN_W-1:0] idx, idx_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [7:0]       cmd_q, cmd_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;

    logic             pkt_valid_nxt;
    logic [7:0]       pkt_cmd_nxt;
    logic [LEN_W-1:0] pkt_len_nxt;
    logic             err_chk_nxt, err_len_nxt, err_timeout_nxt, err_overrun_nxt;
    logic             wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_HUNT;
            sum         <= '0;
            idx         <= '0;
            timer       <= '0;
            cmd_q       <= '0;
            len_q       <= '0;
            pkt_valid   <= 1'b0;
            pkt_cmd     <= '0;
            pkt_len     <= '0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            sum         <= sum_nxt;
            idx         <= idx_nxt;
            timer       <= timer_nxt;
            cmd_q       <= cmd_nxt;
            len_q       <= len_nxt;
            pkt_valid   <= pkt_valid_nxt;
            pkt_cmd     <= pkt_cmd_nxt;
            pkt_len     <= pkt_len_nxt;
            err_chk     <= err_chk_nxt;
            err_len     <= err_len_nxt;
            err_timeout <= err_timeout_nxt;
            err_overrun <= err_overrun_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        sum_nxt         = sum;
        idx_nxt         = idx;
        timer_nxt       = '0;
        cmd_nxt         = cmd_q;
        len_nxt         = len_q;
        pkt_valid_nxt   = pkt_valid;
        pkt_cmd_nxt     = pkt_cmd;
        pkt_len_nxt     = pkt_len;
        err_chk_nxt     = 1'b0;
        err_len_nxt     = 1'b0;
        err_timeout_nxt = 1'b0;
        err_overrun_nxt = 1'b0;
        wr_en           = 1'b0;

        // Inter-byte watchdog inside a packet; a byte in the expiry clk wins.
        if (state inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHK} && !in_valid) begin
            if (timer == TMR_LAST) begin
                err_timeout_nxt = 1'b1;
                state_nxt       = ST_HUNT;
            end else begin
                timer_nxt = timer + TMR_W'(1);
            end
        end

        case (state)
            ST_HUNT: begin
                if (in_valid && in_data == SYNC_BYTE)
                    state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (in_valid) begin
                    cmd_nxt   = in_data;
                    sum_nxt   = in_data;
                    state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (in_valid) begin
                    if (int'(in_data) > MAX_LEN) begin
                        err_len_nxt = 1'b1;
                        state_nxt   = ST_HUNT;
                    end else begin
                        sum_nxt   = chk_add(sum, in_data);
                        len_nxt   = in_data[LEN_W-1:0];
                        idx_nxt   = '0;
                        state_nxt = (in_data == 8'h00) ? ST_CHK : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    sum_nxt = chk_add(sum, in_data);
                    idx_nxt = idx + LEN_W'(1);
                    if (idx == len_q - LEN_W'(1))
                        state_nxt = ST_CHK;
                end
            end
            ST_CHK: begin
                if (in_valid) begin
                    if (in_data == sum) begin
                        pkt_valid_nxt = 1'b1;
                        pkt_cmd_nxt   = cmd_q;
                        pkt_len_nxt   = len_q;
                        state_nxt     = ST_HOLD;
                    end else begin
                        err_chk_nxt = 1'b1;
                        state_nxt   = ST_HUNT;
                    end
                end
            end
            ST_HOLD: begin
                // Bytes arriving while held are dropped even if the ack lands in the same clk.
                if (in_valid)
                    err_overrun_nxt = 1'b1;
                if (pkt_ack) begin
                    pkt_valid_nxt = 1'b0;
                    state_nxt     = ST_HUNT;
                end
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

    pkt_buffer #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (idx[ADDR_W-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_packet_rx_parser.sv
// Randomized bench for packet_rx_parser: packet-level reference (byte lists, modular sums, pulse counts)
// plus directed cases for checksum, length, timeout latency, overrun and reset.
module tb_packet_rx_parser;

    localparam int MAX_LEN = 16;
    localparam int TO      = 40;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int ADDR_W  = $clog2(MAX_LEN);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic              pkt_valid;
    logic [7:0]        pkt_cmd;
    logic [LEN_W-1:0]  pkt_len;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [7:0]        rd_data;
    logic              pkt_ack = 1'b0;
    logic              err_chk, err_len, err_timeout, err_overrun;

    packet_rx_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .pkt_valid(pkt_valid), .pkt_cmd(pkt_cmd), .pkt_len(pkt_len),
        .rd_addr(rd_addr), .rd_data(rd_data), .pkt_ack(pkt_ack),
        .err_chk(err_chk), .err_len(err_len), .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int c_chk, c_len, c_to, c_ovr;
    logic [7:0] pay [MAX_LEN];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, error pulses tallied.
    task automatic tick();
        @(posedge clk); #1;
        c_chk += int'(err_chk);
        c_len += int'(err_len);
        c_to  += int'(err_timeout);
        c_ovr += int'(err_overrun);
    endtask

    task automatic clr();
        c_chk = 0; c_len = 0; c_to = 0; c_ovr = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        in_data = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 8'($urandom);
    endtask

    task automatic gap(input int gmax);
        idle($urandom_range(gmax, 0));
    endtask

    function automatic logic [7:0] non_sync();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hAA) b = 8'h55;
        return b;
    endfunction

    function automatic logic [7:0] pkt_sum(input logic [7:0] cmd, input int len);
        int s;
        s = int'(cmd) + len;
        for (int i = 0; i < len; i++) s += int'(pay[i]);
        return 8'(s % 256);
    endfunction

    task automatic send_pkt(input logic [7:0] cmd, input int len, input logic [7:0] cs, input int gmax);
        send(8'hAA); gap(gmax);
        send(cmd);   gap(gmax);
        send(8'(len));
        for (int i = 0; i < len; i++) begin gap(gmax); send(pay[i]); end
        gap(gmax);
        send(cs);
    endtask

    task automatic held(input string tag, input logic [7:0] cmd, input int len);
        chk({tag, "_valid"}, pkt_valid, 1);
        chk({tag, "_cmd"}, pkt_cmd, cmd);
        chk({tag, "_len"}, pkt_len, len);
        for (int i = 0; i < len; i++) begin
            rd_addr = ADDR_W'(i);
            tick();
            chk({tag, "_rd"}, rd_data, pay[i]);
        end
    endtask

    task automatic ack();
        pkt_ack = 1'b1; tick(); pkt_ack = 1'b0;
        chk("ack_release", pkt_valid, 0);
    endtask

    task automatic cnts(input string tag, input int e_chk, input int e_len, input int e_to, input int e_ovr);
        chk({tag, "_nchk"}, c_chk, e_chk);
        chk({tag, "_nlen"}, c_len, e_len);
        chk({tag, "_nto"},  c_to,  e_to);
        chk({tag, "_novr"}, c_ovr, e_ovr);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] cmd, cs;
        logic [7:0] q [$];
        int len, kind, n, e_ovr, k;

        clr();
        rst = 1'b1; idle(2); rst = 1'b0;
        chk("rst_valid", pkt_valid, 0);
        chk("rst_cmd", pkt_cmd, 0);
        chk("rst_len", pkt_len, 0);
        chk("rst_rd", rd_data, 0);
        chk("rst_errs", {err_chk, err_len, err_timeout, err_overrun}, 0);

        // Reference good packet, readback, overrun, ack+byte in the same clk.
        clr();
        pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30;
        send_pkt(8'h01, 3, 8'h64, 0);
        held("good", 8'h01, 3);
        send(8'h55);
        chk("ovr_pulse", c_ovr, 1);
        held("ovr_keep", 8'h01, 3);
        in_data = 8'hAA; in_valid = 1'b1; pkt_ack = 1'b1;
        tick();
        in_valid = 1'b0; pkt_ack = 1'b0;
        chk("ovr_ack_release", pkt_valid, 0);
        cnts("good", 0, 0, 0, 2);

        // Bad checksum, then immediate repeat accepted.
        clr();
        send_pkt(8'h01, 3, 8'h65, 0);
        chk("badchk_valid", pkt_valid, 0);
        cnts("badchk", 1, 0, 0, 0);
        send_pkt(8'h01, 3, 8'h64, 0);
        held("rpt", 8'h01, 3);
        ack();

        // Oversize length, trailing bytes ignored, then zero-length packet.
        clr();
        send(8'hAA); send(8'h05); send(8'h11);
        send(8'h01); send(8'h02); send(8'h03);
        chk("badlen_valid", pkt_valid, 0);
        cnts("badlen", 0, 1, 0, 0);
        send(8'hAA); send(8'h07); send(8'h00); send(8'h07);
        held("zlen", 8'h07, 0);
        ack();

        // Timeout latency measured from the CMD strobe.
        clr();
        send(8'hAA); send(8'h01);
        n = 0;
        while (err_timeout !== 1'b1 && n < 3 * TO) begin tick(); n++; end
        chk("to_latency", n, TO);
        idle(3);
        cnts("to", 0, 0, 1, 0);

        // Byte landing in the expiry clk is taken.
        clr();
        send(8'hAA); send(8'h07); idle(TO - 1); send(8'h00); idle(TO - 1); send(8'h07);
        held("to_edge", 8'h07, 0);
        ack();
        cnts("to_edge", 0, 0, 0, 0);

        // Reset mid-payload after a packet has left non-zero fields behind.
        clr();
        pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30;
        send_pkt(8'h01, 3, 8'h64, 0);
        rd_addr = '0;
        ack();
        send(8'hAA); send(8'h01); send(8'h03); send(8'h10);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstp_valid", pkt_valid, 0);
        chk("rstp_cmd", pkt_cmd, 0);
        chk("rstp_len", pkt_len, 0);
        chk("rstp_rd", rd_data, 0);
        chk("rstp_errs", {err_chk, err_len, err_timeout, err_overrun}, 0);
        clr();
        pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30;
        send_pkt(8'h01, 3, 8'h64, 1);
        held("after_rst", 8'h01, 3);
        ack();
        cnts("after_rst", 0, 0, 0, 0);

        // Randomized episodes.
        for (int ep = 0; ep < 60; ep++) begin
            clr();
            kind = $urandom_range(3, 0);
            repeat ($urandom_range(3, 0)) send(non_sync());
            cmd = 8'($urandom);
            len = $urandom_range(MAX_LEN, 0);
            for (int i = 0; i < MAX_LEN; i++) pay[i] = 8'($urandom);
            cs = pkt_sum(cmd, len);
            case (kind)
                0: begin
                    send_pkt(cmd, len, cs, ($urandom_range(4, 0) == 0) ? TO - 1 : 3);
                    held("r_good", cmd, len);
                    e_ovr = 0;
                    if ($urandom_range(1, 0) == 1) begin
                        send(8'($urandom)); e_ovr++;
                        held("r_ovr", cmd, len);
                    end
                    if ($urandom_range(1, 0) == 1) begin
                        in_data = 8'($urandom); in_valid = 1'b1; pkt_ack = 1'b1;
                        tick();
                        in_valid = 1'b0; pkt_ack = 1'b0; e_ovr++;
                        chk("r_ovr_ack", pkt_valid, 0);
                    end else begin
                        ack();
                    end
                    cnts("r_good", 0, 0, 0, e_ovr);
                end
                1: begin
                    send_pkt(cmd, len, cs + 8'($urandom_range(255, 1)), 3);
                    chk("r_badchk_valid", pkt_valid, 0);
                    cnts("r_badchk", 1, 0, 0, 0);
                end
                2: begin
                    send(8'hAA); send(cmd); send(8'($urandom_range(255, MAX_LEN + 1)));
                    repeat ($urandom_range(4, 0)) send(non_sync());
                    chk("r_badlen_valid", pkt_valid, 0);
                    cnts("r_badlen", 0, 1, 0, 0);
                end
                default: begin
                    q = {};
                    q.push_back(8'hAA); q.push_back(cmd); q.push_back(8'(len));
                    for (int i = 0; i < len; i++) q.push_back(pay[i]);
                    k = $urandom_range(q.size(), 1);
                    for (int i = 0; i < k; i++) begin gap(3); send(q[i]); end
                    idle(TO + 3);
                    chk("r_to_valid", pkt_valid, 0);
                    cnts("r_to", 0, 0, 1, 0);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
